// File: rtl/rv32e_lsu_pkg.sv
// Shared encodings for the RV32E load/store unit: funct3 values, FSM states
// and fault cause codes.
package rv32e_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MEM  = 2'b01,
    S_WB   = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/rv32e_lsu_align.sv
// Byte-lane steering: replicates store data into lanes with matching strobes,
// and extracts/extends the addressed byte or half of a load word.
module rv32e_lsu_align
  import rv32e_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  assign ld_shift = ld_word >> {ea_lo, 3'b000};

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << ea_lo;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << ea_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32e_lsu.sv
// RV32E load/store unit: checks and issues one access at a time on a valid/ready
// memory bus, writes aligned load data to the register file, flags faults.
module rv32e_lsu
  import rv32e_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, illegal_p0, misalign_p0, fault_p0, timeout_hit;
  logic [31:0]      ea_p0;

  logic [31:0] ea_p1, wdata_p1;
  logic [2:0]  funct3_p1;
  logic [3:0]  rd_p1;
  logic        is_store_p1;
  logic [31:0] rd_data_p2;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;

  assign ea_p0  = req_base + req_offset;
  assign accept = req_valid && (state == S_IDLE);

  always_comb begin
    illegal_p0 = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal_p0 = 1'b0;
      F3_BU, F3_HU:     illegal_p0 = req_is_store;
      default:          illegal_p0 = 1'b1;
    endcase
    misalign_p0 = ((req_funct3[1:0] == 2'b01) && ea_p0[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (ea_p0[1:0] != 2'b00));
    fault_p0    = illegal_p0 || misalign_p0;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: if (accept && !fault_p0) state_nxt = S_MEM;
      S_MEM: begin
        // A ready arriving on the expiry cycle still completes the access.
        if (mem_ready) begin
          state_nxt = is_store_p1 ? S_IDLE : S_WB;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // p0 -> p1: latch the accepted request; p1 -> p2: capture load lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      ea_p1       <= '0;
      wdata_p1    <= '0;
      funct3_p1   <= '0;
      rd_p1       <= '0;
      is_store_p1 <= 1'b0;
      rd_data_p2  <= '0;
      exc_valid   <= 1'b0;
      exc_cause   <= '0;
      exc_addr    <= '0;
    end else begin
      exc_valid <= 1'b0;
      if ((state == S_MEM) && !mem_ready) cnt <= cnt + 1'b1;
      else                                cnt <= '0;
      if (accept && !fault_p0) begin
        ea_p1       <= ea_p0;
        wdata_p1    <= req_wdata;
        funct3_p1   <= req_funct3;
        rd_p1       <= req_rd;
        is_store_p1 <= req_is_store;
      end
      if (accept && fault_p0) begin
        exc_valid <= 1'b1;
        exc_cause <= illegal_p0 ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
        exc_addr  <= ea_p0;
      end else if (timeout_hit) begin
        exc_valid <= 1'b1;
        exc_cause <= CAUSE_TIMEOUT;
        exc_addr  <= ea_p1;
      end
      if ((state == S_MEM) && mem_ready && !is_store_p1) rd_data_p2 <= ld_data;
    end
  end

  rv32e_lsu_align u_align (
    .funct3   (funct3_p1),
    .ea_lo    (ea_p1[1:0]),
    .st_data  (wdata_p1),
    .ld_word  (mem_rdata),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_data  (ld_data)
  );

  assign req_ready = (state == S_IDLE);
  assign mem_valid = (state == S_MEM);
  assign mem_addr  = {ea_p1[31:2], 2'b00};
  assign mem_wdata = st_wdata;
  assign mem_wstrb = is_store_p1 ? st_wstrb : 4'b0000;
  assign rd_addr   = rd_p1;
  assign rd_data   = rd_data_p2;
  assign rd_we     = (state == S_WB) && (rd_p1 != 4'd0);

endmodule

// File: tb/tb_rv32e_lsu.sv
// Randomized and directed bench for rv32e_lsu against an arithmetic reference
// model of RISC-V load/store semantics.
module tb_rv32e_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_base = '0, req_offset = '0, req_wdata = '0;
  logic [3:0]  req_rd = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        req_ready, mem_valid, rd_we, exc_valid;
  logic [31:0] mem_addr, mem_wdata, rd_data, exc_addr;
  logic [3:0]  mem_wstrb, rd_addr;
  logic [1:0]  exc_cause;

  int checks = 0;
  int failures = 0;

  rv32e_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes and legality from the ISA definition
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_legal(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea,
                                             input logic [31:0] word);
    int          sz   = acc_size(f3);
    logic [31:0] v    = word >> (8 * (ea % 4));
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    v = v & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = acc_size(f3);
    if (sz == 1) return d[7:0] * 32'h0101_0101;
    if (sz == 2) return d[15:0] * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] ea);
    int sz = acc_size(f3);
    int lanes = (1 << sz) - 1;
    return 4'(lanes << (ea % 4));
  endfunction

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, input logic [3:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    check_val("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] wd, input logic [3:0] rd,
                           input int waitc, input logic [31:0] rdata);
    logic [31:0] ea = base + off;
    int          sz = acc_size(f3);
    issue(st, f3, base, off, wd, rd);
    if (!is_legal(st, f3) || (ea % sz) != 0) begin
      check_val("fault_valid", {31'd0, exc_valid}, 32'd1);
      check_val("fault_cause", {30'd0, exc_cause}, is_legal(st, f3) ? 32'd1 : 32'd2);
      check_val("fault_addr", exc_addr, ea);
      check_val("fault_no_mem", {31'd0, mem_valid}, 32'd0);
      step();
      check_val("fault_pulse", {31'd0, exc_valid}, 32'd0);
      check_val("fault_no_mem2", {31'd0, mem_valid}, 32'd0);
      return;
    end
    check_val("mem_valid", {31'd0, mem_valid}, 32'd1);
    check_val("mem_addr", mem_addr, {ea[31:2], 2'b00});
    check_val("mem_wstrb", {28'd0, mem_wstrb}, st ? {28'd0, model_wstrb(f3, ea)} : 32'd0);
    if (st) check_val("mem_wdata", mem_wdata, model_wdata(f3, wd));
    for (int n = 0; n < waitc; n++) begin
      step();
      check_val("mem_hold", {31'd0, mem_valid}, 32'd1);
      check_val("mem_addr_hold", mem_addr, {ea[31:2], 2'b00});
    end
    mem_ready = 1'b1; mem_rdata = rdata;
    step();
    mem_ready = 1'b0; mem_rdata = $urandom;
    check_val("no_exc", {31'd0, exc_valid}, 32'd0);
    check_val("mem_dropped", {31'd0, mem_valid}, 32'd0);
    if (st) begin
      check_val("store_no_we", {31'd0, rd_we}, 32'd0);
      check_val("store_idle", {31'd0, req_ready}, 32'd1);
    end else begin
      check_val("rd_we", {31'd0, rd_we}, (rd != 0) ? 32'd1 : 32'd0);
      if (rd != 0) begin
        check_val("rd_addr", {28'd0, rd_addr}, {28'd0, rd});
        check_val("rd_data", rd_data, model_load(f3, ea, rdata));
      end
      step();
      check_val("rd_we_pulse", {31'd0, rd_we}, 32'd0);
      check_val("load_idle", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    int cyc;
    step();
    step();
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_val("rst_rd_we", {31'd0, rd_we}, 32'd0);
    check_val("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    check_val("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    step();

    // Directed cases
    do_access(1'b0, 3'd2, 32'h100, 32'd4, 32'd0, 4'd5, 0, 32'hDEADBEEF);
    do_access(1'b0, 3'd0, 32'h100, 32'd3, 32'd0, 4'd6, 0, 32'h80FF_0000);
    do_access(1'b0, 3'd4, 32'h100, 32'd3, 32'd0, 4'd7, 1, 32'h80FF_0000);
    do_access(1'b0, 3'd1, 32'h100, 32'd2, 32'd0, 4'd8, 0, 32'h80FF_0000);
    do_access(1'b1, 3'd1, 32'h200, 32'd2, 32'h1234ABCD, 4'd9, 0, 32'd0);
    do_access(1'b0, 3'd2, 32'h100, 32'd1, 32'd0, 4'd3, 0, 32'd0);
    do_access(1'b0, 3'd3, 32'h100, 32'd0, 32'd0, 4'd3, 0, 32'd0);
    do_access(1'b1, 3'd4, 32'h101, 32'd0, 32'd0, 4'd3, 0, 32'd0);
    do_access(1'b0, 3'd2, 32'hFFFF_FFFC, 32'd8, 32'd0, 4'd0, 0, 32'h1111_2222);
    do_access(1'b0, 3'd2, 32'h300, 32'd0, 32'd0, 4'd2, 3, 32'hCAFE_F00D);

    // Timeout: ready never comes
    issue(1'b0, 3'd2, 32'h400, 32'h10, 32'd0, 4'd4);
    cyc = 0;
    while (mem_valid && cyc < 20) begin
      cyc++;
      step();
    end
    check_val("tmo_cycles", cyc, 32'd4);
    check_val("tmo_exc", {31'd0, exc_valid}, 32'd1);
    check_val("tmo_cause", {30'd0, exc_cause}, 32'd3);
    check_val("tmo_addr", exc_addr, 32'h410);
    check_val("tmo_no_we", {31'd0, rd_we}, 32'd0);
    do_access(1'b1, 3'd0, 32'h500, 32'd1, 32'h0000_00A5, 4'd1, 0, 32'd0);

    // Reset during MEM
    issue(1'b0, 3'd2, 32'h600, 32'd0, 32'd0, 4'd11);
    check_val("rstmid_mem", {31'd0, mem_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_drop", {31'd0, mem_valid}, 32'd0);
    check_val("rstmid_ready", {31'd0, req_ready}, 32'd1);
    mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check_val("rstmid_no_we", {31'd0, rd_we}, 32'd0);
      check_val("rstmid_no_mem", {31'd0, mem_valid}, 32'd0);
    end
    mem_ready = 1'b0;

    // Randomized accesses
    for (int n = 0; n < 150; n++) begin
      bit          st  = 1'($urandom_range(0, 1));
      logic [2:0]  f3  = 3'($urandom_range(0, 7));
      logic [31:0] bs  = $urandom;
      logic [31:0] off = 32'($signed(12'($urandom)));
      if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      if ($urandom_range(0, 3) != 0) off[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) bs[1:0] = 2'b00;
      do_access(st, f3, bs, off, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
